// File: rtl/shift_stage_32.sv
// rtl/shift_stage_32.sv - two-stage pipelined 32-bit shift unit with valid/ready on both sides
// Optional feature macro: SHIFT_STAGE_ZERO_FLAG_EN (adds a registered zero flag output)

// Right-only logarithmic barrel shifter; vacated upper bits take the fill bit.
module barrel_shift_right_32 (
  input  logic [31:0] data_i,
  input  logic        fill_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] shifted_o
);

  logic [31:0] st0, st1, st2, st3;

  // Five mux levels, one per shift-amount bit (1, 2, 4, 8, 16).
  always_comb begin
    st0       = shamt_i[0] ? {fill_i, data_i[31:1]}       : data_i;
    st1       = shamt_i[1] ? {{2{fill_i}}, st0[31:2]}     : st0;
    st2       = shamt_i[2] ? {{4{fill_i}}, st1[31:4]}     : st1;
    st3       = shamt_i[3] ? {{8{fill_i}}, st2[31:8]}     : st2;
    shifted_o = shamt_i[4] ? {{16{fill_i}}, st3[31:16]}   : st3;
  end

endmodule

module shift_stage_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
  ,
  output logic        zero
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_state_e;

  stage_state_e s1_state_q, s1_state_d;
  stage_state_e s2_state_q, s2_state_d;

  logic [31:0] s1_data_q, s1_data_d;
  logic [4:0]  s1_shamt_q, s1_shamt_d;
  logic        s1_fill_q, s1_fill_d;
  logic        s1_left_q, s1_left_d;
  logic [31:0] s2_data_q, s2_data_d;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
  logic        s2_zero_q, s2_zero_d;
`endif

  logic        s1_valid, s2_valid;
  logic        s2_adv, accept;
  logic [31:0] shifted;
  logic [31:0] s2_result;

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Left shifts reuse the right shifter: operand reversed in S1, result reversed back here.
  barrel_shift_right_32 u_shifter (
    .data_i   (s1_data_q),
    .fill_i   (s1_fill_q),
    .shamt_i  (s1_shamt_q),
    .shifted_o(shifted)
  );

  // Handshake: S2 drains or is empty lets S1 advance; S1 free or advancing accepts input.
  always_comb begin
    s1_valid  = (s1_state_q == FULL);
    s2_valid  = (s2_state_q == FULL);
    s2_adv    = s1_valid && (!s2_valid || out_ready);
    in_ready  = !s1_valid || s2_adv;
    accept    = in_valid && in_ready;
    s2_result = s1_left_q ? bitrev(shifted) : shifted;
  end

  // Per-stage EMPTY/FULL next state and operand/result capture.
  always_comb begin
    s1_state_d = s1_state_q;
    s1_data_d  = s1_data_q;
    s1_shamt_d = s1_shamt_q;
    s1_fill_d  = s1_fill_q;
    s1_left_d  = s1_left_q;
    s2_state_d = s2_state_q;
    s2_data_d  = s2_data_q;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
    s2_zero_d  = s2_zero_q;
`endif

    if (accept) begin
      s1_state_d = FULL;
      s1_data_d  = op[0] ? a : bitrev(a);
      s1_shamt_d = shamt;
      s1_fill_d  = (op == 2'b11) ? a[31] : 1'b0;
      s1_left_d  = ~op[0];
    end else if (s2_adv) begin
      s1_state_d = EMPTY;
    end

    if (s2_adv) begin
      s2_state_d = FULL;
      s2_data_d  = s2_result;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
      s2_zero_d  = ~|s2_result;
`endif
    end else if (out_ready) begin
      s2_state_d = EMPTY;
    end
  end

  // Pipeline registers; reset discards any in-flight requests immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_state_q <= EMPTY;
      s2_state_q <= EMPTY;
      s1_data_q  <= 32'h0;
      s1_shamt_q <= 5'h0;
      s1_fill_q  <= 1'b0;
      s1_left_q  <= 1'b0;
      s2_data_q  <= 32'h0;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
      s2_zero_q  <= 1'b0;
`endif
    end else begin
      s1_state_q <= s1_state_d;
      s2_state_q <= s2_state_d;
      s1_data_q  <= s1_data_d;
      s1_shamt_q <= s1_shamt_d;
      s1_fill_q  <= s1_fill_d;
      s1_left_q  <= s1_left_d;
      s2_data_q  <= s2_data_d;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
      s2_zero_q  <= s2_zero_d;
`endif
    end
  end

  // Output view of S2.
  always_comb begin
    out_valid = s2_valid;
    result    = s2_data_q;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
    zero      = s2_zero_q;
`endif
  end

endmodule

// File: tb/tb_shift_stage_32.sv
// tb/tb_shift_stage_32.sv - scoreboard bench for shift_stage_32
module tb_shift_stage_32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
  logic        zero;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [32:0] exp_q[$];

  shift_stage_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .shamt    (shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [31:0] av, input logic [4:0] sh,
                      input logic [31:0] exp);
    in_valid = 1'b1;
    op       = o;
    a        = av;
    shamt    = sh;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({(exp == 32'h0), exp});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 32'h0);
  endtask

  // Monitor: pops an expected entry on every output handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_output: got %h expected none", result);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e[31:0]);
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
        check("zero", {31'h0, zero}, {31'h0, e[32]});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 2'b00;
    a         = 32'h0;
    shamt     = 5'h0;
    out_ready = 1'b1;
    #1;
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_result", result, 32'h0);
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
    check("reset_zero", {31'h0, zero}, 32'h0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, visible after edge N+1.
    send(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
    @(negedge clk);
    check("latency_not_early", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("latency_valid", {31'h0, out_valid}, 32'h1);
    check("latency_result", result, 32'h8000_0000);
    @(posedge clk);
    #1;

    // Directed vectors, back-to-back.
    send(2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    send(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    send(2'b11, 32'h7000_0000, 5'd4,  32'h0700_0000);
    send(2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000);
    send(2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    send(2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    send(2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    send(2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    send(2'b10, 32'hDEAD_BEEF, 5'd8,  32'hADBE_EF00);
    send(2'b00, 32'hDEAD_BEEF, 5'd4,  32'hEADB_EEF0);
    send(2'b11, 32'h0F00_0000, 5'd20, 32'h0000_00F0);
`ifdef SHIFT_STAGE_ZERO_FLAG_EN
    send(2'b01, 32'h0000_00FF, 5'd8,  32'h0000_0000);
    send(2'b01, 32'h0000_00FF, 5'd7,  32'h0000_0001);
`endif
    drain();
    @(posedge clk);
    #1;

    // Backpressure: two accepted, third stalls, result held.
    out_ready = 1'b0;
    send(2'b01, 32'hDEAD_BEEF, 5'd4, 32'h0DEA_DBEE);
    send(2'b00, 32'hDEAD_BEEF, 5'd4, 32'hEADB_EEF0);
    in_valid = 1'b1;
    op       = 2'b11;
    a        = 32'hDEAD_BEEF;
    shamt    = 5'd4;
    @(negedge clk);
    check("stall_in_ready", {31'h0, in_ready}, 32'h0);
    check("stall_out_valid", {31'h0, out_valid}, 32'h1);
    check("stall_result", result, 32'h0DEA_DBEE);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_in_ready_2", {31'h0, in_ready}, 32'h0);
    check("stall_result_held", result, 32'h0DEA_DBEE);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'b11, 32'hDEAD_BEEF, 5'd4, 32'hFDEA_DBEE);
    @(negedge clk);
    check("burst_valid_2", {31'h0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("burst_valid_3", {31'h0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("burst_done", {31'h0, out_valid}, 32'h0);
    check("burst_queue_empty", exp_q.size(), 32'h0);
    @(posedge clk);
    #1;

    // Reset with both stages full discards everything.
    out_ready = 1'b0;
    send(2'b01, 32'h1234_5678, 5'd4, 32'h0123_4567);
    send(2'b00, 32'h1234_5678, 5'd4, 32'h2345_6780);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("async_reset_result", result, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_output", {31'h0, out_valid}, 32'h0);
    end
    check("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    send(2'b01, 32'h0000_0100, 5'd8, 32'h0000_0001);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
